// File: rtl/boa_extmem_sram_target.sv
// Byte-wide SRAM target for the extmem 4-beat word-burst interface: word storage,
// per-burst write merging with atomic commit on beat 3, read forwarding and a protocol checker.
module boa_extmem_sram_target #(
   parameter int sram_alen = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 xm_re,
   input  logic                 xm_we,
   input  logic [sram_alen-1:0] xm_addr,
   input  logic [7:0]           xm_wdata,
   output logic [7:0]           xm_rdata,
   output logic                 err_seq,
   output logic                 err_rw,
   output logic [15:0]          rd_count,
   output logic [15:0]          wr_count
);
   localparam int WAW   = sram_alen - 2;
   localparam int DEPTH = 1 << WAW;

   logic [31:0] mem [0:DEPTH-1];

   logic [WAW-1:0]  word;
   logic [1:0]      lane;
   logic [3:0][7:0] buf_q, buf_d;
   logic [3:0]      mask_q, mask_d;
   logic [WAW-1:0]  pend_q, pend_d;
   logic [1:0]      last_q, last_d;
   logic            err_seq_q, err_seq_d;
   logic            err_rw_q, err_rw_d;
   logic [15:0]     rd_cnt_q, rd_cnt_d;
   logic [15:0]     wr_cnt_q, wr_cnt_d;

   logic            violation;
   logic            commit;
   logic [3:0]      cur_mask;
   logic [3:0][7:0] cur_data;
   logic [31:0]     rd_word;

   assign word = xm_addr[sram_alen-1:2];
   assign lane = xm_addr[1:0];

   always_comb begin
      violation = (mask_q != 4'b0000) && ((word != pend_q) || (lane <= last_q));
      // A violation drops the old buffer; the current beat then starts afresh.
      cur_mask  = violation ? 4'b0000 : mask_q;
      cur_data  = buf_q;
      if (xm_we) begin
         cur_mask[lane] = 1'b1;
         cur_data[lane] = xm_wdata;
      end
      commit    = (lane == 2'd3) && (cur_mask != 4'b0000);

      mask_d    = mask_q;
      buf_d     = buf_q;
      pend_d    = pend_q;
      last_d    = last_q;
      err_seq_d = err_seq_q | violation;
      err_rw_d  = err_rw_q | (xm_re & xm_we);
      rd_cnt_d  = (xm_re && lane == 2'd3) ? rd_cnt_q + 16'd1 : rd_cnt_q;
      wr_cnt_d  = wr_cnt_q;

      if (commit) begin
         mask_d   = 4'b0000;
         pend_d   = word;
         last_d   = lane;
         wr_cnt_d = wr_cnt_q + 16'd1;
      end else if (xm_we) begin
         mask_d = cur_mask;
         buf_d  = cur_data;
         pend_d = word;
         last_d = lane;
      end else if (violation) begin
         mask_d = 4'b0000;
      end else if (mask_q != 4'b0000 && lane > last_q) begin
         last_d = lane;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mask_q    <= 4'b0000;
         pend_q    <= '0;
         last_q    <= 2'd0;
         err_seq_q <= 1'b0;
         err_rw_q  <= 1'b0;
         rd_cnt_q  <= 16'd0;
         wr_cnt_q  <= 16'd0;
      end else begin
         mask_q    <= mask_d;
         pend_q    <= pend_d;
         last_q    <= last_d;
         err_seq_q <= err_seq_d;
         err_rw_q  <= err_rw_d;
         rd_cnt_q  <= rd_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
      end
      buf_q <= buf_d;
   end

   // Byte-masked commit; a burst interrupted by reset never reaches memory.
   always_ff @(posedge clk) begin
      if (!rst && commit) begin
         for (int i = 0; i < 4; i++) begin
            if (cur_mask[i]) mem[word][8*i +: 8] <= cur_data[i];
         end
      end
   end

   always_comb begin
      rd_word = mem[word];
      if (mask_q[lane] && pend_q == word) xm_rdata = buf_q[lane];
      else                                xm_rdata = rd_word[{lane, 3'b000} +: 8];
   end

   assign err_seq  = err_seq_q;
   assign err_rw   = err_rw_q;
   assign rd_count = rd_cnt_q;
   assign wr_count = wr_cnt_q;
endmodule
